dram_cache_port_sched: RTL

Single-port command scheduler in front of the cache DRAM. It shares one command port between tag-hit read requests from the tag comparator and fill writes drained from the fill FIFO. Reads have priority, with two exceptions: a high/low watermark drain mode, and a starvation limit that forces fill writes through. Commands are issued one at a time on a registered valid/ready port.

---
 rtl/dram_cache_port_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dram_cache_port_sched.sv
// Single-port command scheduler in front of the cache DRAM.
// Arbitrates tag-hit reads against fill-FIFO writes onto one registered
// valid/ready command port. Reads win by default; a watermark drain mode and
// a starvation limit force fill writes through.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rd_valid_i/rd_ready_o/rd_addr_i       read request handshake (ready is combinational)
//   fifo_empty_i/fifo_cnt_i/fifo_data_i   show-ahead fill FIFO status and head {addr, data}
//   fifo_rden_o                           pop fill FIFO (combinational)
//   cmd_valid_o/cmd_ready_i               command handshake (valid registered)
//   cmd_write_o/cmd_addr_o/cmd_data_o     registered command payload

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module dram_cache_port_sched #(
  parameter int unsigned ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = `AXI_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH    = 5,
  parameter int unsigned HI_WM        = 12,
  parameter int unsigned LO_WM        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_valid_i,
  output logic                           rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
  input  logic                           fifo_empty_i,
  input  logic [CNT_WIDTH-1:0]           fifo_cnt_i,
  output logic                           fifo_rden_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_data_i,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output logic                           cmd_write_o,
  output logic [ADDR_WIDTH-1:0]          cmd_addr_o,
  output logic [DATA_WIDTH-1:0]          cmd_data_o
);

  localparam int unsigned FD_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [CNT_WIDTH-1:0] HI_CNT     = CNT_WIDTH'(HI_WM);
  localparam logic [CNT_WIDTH-1:0] LO_CNT     = CNT_WIDTH'(LO_WM);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]            state, state_nxt;
  logic                  drain_mode, drain_nxt;
  logic [CNT_WIDTH-1:0]  starve_cnt, starve_nxt;
  logic                  cmd_valid_nxt;
  logic                  cmd_write_nxt;
  logic [ADDR_WIDTH-1:0] cmd_addr_nxt;
  logic [DATA_WIDTH-1:0] cmd_data_nxt;
  logic                  wr_force;
  logic                  wr_grant;

  // Write is forced ahead of reads by drain mode or an exhausted starvation budget.
  assign wr_force = !fifo_empty_i && (drain_mode || (starve_cnt == STARVE_MAX));
  assign wr_grant = wr_force || (!rd_valid_i && !fifo_empty_i);

  // Next-state, grant and payload selection.
  always_comb begin
    state_nxt     = state;
    drain_nxt     = drain_mode;
    starve_nxt    = starve_cnt;
    cmd_valid_nxt = cmd_valid_o;
    cmd_write_nxt = cmd_write_o;
    cmd_addr_nxt  = cmd_addr_o;
    cmd_data_nxt  = cmd_data_o;
    rd_ready_o    = 1'b0;
    fifo_rden_o   = 1'b0;

    case (state)
      S_IDLE: begin
        if (wr_grant) begin
          fifo_rden_o   = 1'b1;
          cmd_valid_nxt = 1'b1;
          cmd_write_nxt = 1'b1;
          cmd_addr_nxt  = fifo_data_i[FD_WIDTH-1 -: ADDR_WIDTH];
          cmd_data_nxt  = fifo_data_i[DATA_WIDTH-1:0];
          starve_nxt    = '0;
          state_nxt     = S_ISSUE;
        end else if (rd_valid_i) begin
          rd_ready_o    = 1'b1;
          cmd_valid_nxt = 1'b1;
          cmd_write_nxt = 1'b0;
          cmd_addr_nxt  = rd_addr_i;
          cmd_data_nxt  = '0;
          // Saturating: a write is forced before the count could pass the limit.
          if (!fifo_empty_i && (starve_cnt != STARVE_MAX))
            starve_nxt = starve_cnt + CNT_WIDTH'(1);
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready_i) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Watermark hysteresis, evaluated every cycle regardless of state.
    if (fifo_cnt_i >= HI_CNT)
      drain_nxt = 1'b1;
    else if (fifo_cnt_i <= LO_CNT)
      drain_nxt = 1'b0;

    // Starvation only accrues while fills are actually waiting.
    if (fifo_empty_i)
      starve_nxt = '0;

    // Handshake strobes stay low while reset is held.
    if (!rst_n) begin
      rd_ready_o  = 1'b0;
      fifo_rden_o = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      drain_mode  <= 1'b0;
      starve_cnt  <= '0;
      cmd_valid_o <= 1'b0;
      cmd_write_o <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      drain_mode  <= drain_nxt;
      starve_cnt  <= starve_nxt;
      cmd_valid_o <= cmd_valid_nxt;
      cmd_write_o <= cmd_write_nxt;
      cmd_addr_o  <= cmd_addr_nxt;
      cmd_data_o  <= cmd_data_nxt;
    end
  end

endmodule
